// File: rtl/uart_ctrl.sv
// uart_ctrl: register-mapped TX/RX FIFO controller sequencing a UART core
// through its send/TxBusy handshake and holding its mode/divisor setup.
module uart_ctrl #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        irq,
   output logic [7:0]  uart_mode,
   output logic [15:0] uart_div,
   output logic        uart_send,
   output logic [7:0]  uart_txreg,
   input  logic        uart_txbusy,
   input  logic [7:0]  uart_rxreg,
   input  logic        uart_rxerr,
   input  logic        uart_rxint
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

   state_t        r_state, w_next;
   logic [7:0]    r_tx_mem [DEPTH];
   logic [7:0]    r_rx_mem [DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [AW:0]   r_tx_cnt, r_rx_cnt;
   logic [9:0]    r_mode;
   logic [15:0]   r_div, r_rdata;
   logic [7:0]    r_txreg;
   logic          r_tx_ovf, r_rx_ovf, r_rx_err;
   logic          r_busy_s1, r_busy_s2, r_rxint_s1, r_rxint_s2, r_rxint_d, r_rxerr_s1, r_rxerr_s2;
   logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_rx_evt;
   logic          w_data_wr, w_stat_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_tx_active;
   logic [15:0]   w_status, w_rdata;

   assign w_tx_empty  = r_tx_cnt == '0;
   assign w_tx_full   = r_tx_cnt == FULL;
   assign w_rx_empty  = r_rx_cnt == '0;
   assign w_rx_full   = r_rx_cnt == FULL;
   assign w_rx_evt    = r_rxint_s2 & ~r_rxint_d;
   assign w_data_wr   = wr_en & (addr == 2'd0);
   assign w_stat_wr   = wr_en & (addr == 2'd1);
   assign w_tx_push   = w_data_wr & ~w_tx_full;
   assign w_rx_push   = w_rx_evt & ~w_rx_full;
   assign w_rx_pop    = rd_en & (addr == 2'd0) & ~w_rx_empty;
   assign w_tx_active = r_state != IDLE;

   assign w_status = {1'b0, 7'(r_rx_cnt), r_rx_err, r_rx_ovf, r_tx_ovf, w_tx_active,
                      w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
   assign w_rdata  = (addr == 2'd0) ? (w_rx_empty ? 16'h0000 : {8'h00, r_rx_mem[r_rx_rp]}) :
                     (addr == 2'd1) ? w_status :
                     (addr == 2'd2) ? {6'b0, r_mode} : r_div;

   always_comb begin
      w_next    = r_state;
      w_tx_pop  = 1'b0;
      uart_send = 1'b0;
      w_next    = (r_state == IDLE) ? (w_tx_empty ? IDLE : REQ) :
                  (r_state == REQ)  ? (r_busy_s2 ? BUSY : REQ) :
                                      (r_busy_s2 ? BUSY : IDLE);
      w_tx_pop  = (r_state == IDLE) & ~w_tx_empty;
      uart_send = r_state == REQ;
   end

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
      if (w_rx_push) r_rx_mem[r_rx_wp] <= uart_rxreg;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_tx_cnt   <= '0;
         r_rx_cnt   <= '0;
         r_mode     <= '0;
         r_div      <= 16'h0048;
         r_rdata    <= '0;
         r_txreg    <= '0;
         r_tx_ovf   <= 1'b0;
         r_rx_ovf   <= 1'b0;
         r_rx_err   <= 1'b0;
         r_busy_s1  <= 1'b0;
         r_busy_s2  <= 1'b0;
         r_rxint_s1 <= 1'b0;
         r_rxint_s2 <= 1'b0;
         r_rxint_d  <= 1'b0;
         r_rxerr_s1 <= 1'b0;
         r_rxerr_s2 <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_busy_s1  <= uart_txbusy;
         r_busy_s2  <= r_busy_s1;
         r_rxint_s1 <= uart_rxint;
         r_rxint_s2 <= r_rxint_s1;
         r_rxint_d  <= r_rxint_s2;
         r_rxerr_s1 <= uart_rxerr;
         r_rxerr_s2 <= r_rxerr_s1;
         if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
         if (w_tx_pop) begin
            r_tx_rp <= r_tx_rp + AW'(1);
            r_txreg <= r_tx_mem[r_tx_rp];
         end
         if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
         if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
         r_tx_cnt <= r_tx_cnt + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);
         r_rx_cnt <= r_rx_cnt + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);
         // a sticky set in the same cycle as its clear wins, so no event is lost
         r_tx_ovf <= (r_tx_ovf & ~(w_stat_wr & wdata[5])) | (w_data_wr & w_tx_full);
         r_rx_ovf <= (r_rx_ovf & ~(w_stat_wr & wdata[6])) | (w_rx_evt & w_rx_full);
         r_rx_err <= (r_rx_err & ~(w_stat_wr & wdata[7])) | (w_rx_evt & r_rxerr_s2);
         if (wr_en && addr == 2'd2) r_mode <= wdata[9:0];
         if (wr_en && addr == 2'd3) r_div <= wdata;
         if (rd_en) r_rdata <= w_rdata;
      end
   end

   assign rdata      = r_rdata;
   assign uart_mode  = r_mode[7:0];
   assign uart_div   = r_div;
   assign uart_txreg = r_txreg;
   assign irq        = (r_mode[8] & ~w_rx_empty) | (r_mode[9] & w_tx_empty & (r_state == IDLE));
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl with TX/RX/read scoreboards.
module tb_uart_ctrl;
   logic        clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [1:0]  addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata, uart_div;
   logic        irq, uart_send;
   logic [7:0]  uart_mode, uart_txreg;
   logic        uart_txbusy = 1'b0, uart_rxerr = 1'b0, uart_rxint = 1'b0;
   logic [7:0]  uart_rxreg = '0;
   int          n_cmp = 0, n_err = 0;
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   logic [15:0] expq[$];
   logic [15:0] held;

   uart_ctrl #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irq(irq), .uart_mode(uart_mode), .uart_div(uart_div),
      .uart_send(uart_send), .uart_txreg(uart_txreg), .uart_txbusy(uart_txbusy),
      .uart_rxreg(uart_rxreg), .uart_rxerr(uart_rxerr), .uart_rxint(uart_rxint)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] a, input logic [15:0] exp);
      expq.push_back(exp);
      rd_en = 1'b1;
      addr  = a;
      tick();
      rd_en = 1'b0;
      chk(tag, rdata, expq.pop_front());
   endtask

   task automatic rdrx(input string tag);
      logic [15:0] exp;
      exp   = (rxq.size() != 0) ? {8'h00, rxq.pop_front()} : 16'h0000;
      rd_en = 1'b1;
      addr  = 2'd0;
      tick();
      rd_en = 1'b0;
      chk(tag, rdata, exp);
   endtask

   task automatic txchk(input string tag);
      logic [7:0] exp;
      exp = (txq.size() != 0) ? txq.pop_front() : 8'hxx;
      chk({tag, "_send"}, 16'(uart_send), 16'h1);
      chk(tag, 16'(uart_txreg), 16'(exp));
   endtask

   task automatic rxpulse(input logic [7:0] b, input logic e);
      uart_rxreg = b;
      uart_rxerr = e;
      uart_rxint = 1'b1;
      repeat (3) tick();
      uart_rxint = 1'b0;
      uart_rxerr = 1'b0;
      repeat (3) tick();
   endtask

   task automatic busy_pulse();
      uart_txbusy = 1'b1;
      repeat (3) tick();
      uart_txbusy = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_send", 16'(uart_send), 16'h0);
      chk("rst_irq", 16'(irq), 16'h0);
      chk("rst_txreg", 16'(uart_txreg), 16'h0);
      chk("rst_mode_out", 16'(uart_mode), 16'h0);
      chk("rst_div_out", uart_div, 16'h0048);
      chk("rst_rdata", rdata, 16'h0);
      rst = 1'b1;
      tick();
      rdchk("rst_status", 2'd1, 16'h0005);
      rdchk("rst_mode", 2'd2, 16'h0000);
      rdchk("rst_div", 2'd3, 16'h0048);

      wr(2'd3, 16'h1234);
      chk("div_out", uart_div, 16'h1234);
      rdchk("div_rd", 2'd3, 16'h1234);
      wr(2'd2, 16'h0203);
      chk("mode_out", 16'(uart_mode), 16'h0003);
      chk("irq_tx_idle", 16'(irq), 16'h1);
      rdchk("mode_rd", 2'd2, 16'h0203);
      held = rdata;
      repeat (3) tick();
      chk("rdata_hold", rdata, held);

      txq.push_back(8'hA5);
      wr(2'd0, 16'h00A5);
      chk("tx_not_yet", 16'(uart_send), 16'h0);
      chk("irq_tx_pending", 16'(irq), 16'h0);
      tick();
      txchk("tx_single");
      rdchk("status_req", 2'd1, 16'h0015);
      uart_txbusy = 1'b1;
      repeat (3) tick();
      chk("send_drop", 16'(uart_send), 16'h0);
      repeat (47) tick();
      uart_txbusy = 1'b0;
      repeat (2) tick();
      chk("irq_busy", 16'(irq), 16'h0);
      tick();
      chk("irq_idle", 16'(irq), 16'h1);
      wr(2'd2, 16'h0000);

      for (int i = 0; i < 10; i++) begin
         if (i < 9) txq.push_back(8'(8'h10 + i));
         wr(2'd0, 16'(8'h10 + i));
      end
      txchk("ovf_req");
      rdchk("ovf_status", 2'd1, 16'h0036);
      wr(2'd1, 16'h0020);
      rdchk("ovf_clear", 2'd1, 16'h0016);
      for (int i = 0; i < 8; i++) begin
         busy_pulse();
         txchk($sformatf("drain%0d", i));
      end
      busy_pulse();
      rdchk("drain_done", 2'd1, 16'h0005);

      wr(2'd2, 16'h0100);
      chk("irq_rx_empty", 16'(irq), 16'h0);
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) rxq.push_back(8'(i));
         rxpulse(8'(i), 1'b0);
      end
      chk("irq_rx", 16'(irq), 16'h1);
      rdchk("rx_status", 2'd1, 16'h0849);
      for (int i = 0; i < 8; i++) rdrx($sformatf("rx_rd%0d", i));
      chk("irq_rx_drained", 16'(irq), 16'h0);
      rdchk("rx_empty_rd", 2'd0, 16'h0000);
      wr(2'd1, 16'h0040);
      rdchk("rx_ovf_clear", 2'd1, 16'h0005);

      rxq.push_back(8'h3C);
      rxpulse(8'h3C, 1'b1);
      rdchk("rx_err_status", 2'd1, 16'h0181);
      rxq.push_back(8'h5A);
      uart_rxreg = 8'h5A;
      uart_rxint = 1'b1;
      repeat (2) tick();
      rdrx("rx_simul_rd");
      uart_rxint = 1'b0;
      repeat (3) tick();
      rdchk("rx_simul_cnt", 2'd1, 16'h0181);
      rdrx("rx_simul_next");
      wr(2'd1, 16'h0080);
      rdchk("rx_err_clear", 2'd1, 16'h0005);

      wr(2'd2, 16'h0000);
      txq.push_back(8'h77);
      wr(2'd0, 16'h0077);
      wr(2'd0, 16'h0088);
      txchk("rst_mid_req");
      rst = 1'b0;
      tick();
      chk("rst_mid_send", 16'(uart_send), 16'h0);
      chk("rst_mid_txreg", 16'(uart_txreg), 16'h0);
      rst = 1'b1;
      repeat (2) tick();
      chk("rst_mid_nosend", 16'(uart_send), 16'h0);
      rdchk("rst_mid_status", 2'd1, 16'h0005);
      rdchk("rst_mid_div", 2'd3, 16'h0048);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Register-mapped controller that sequences the UART core (baud generator, transmitter, receiver). It buffers transmit bytes in a TX FIFO and feeds them one at a time through the core's send/TxBusy handshake. It captures received bytes into an RX FIFO and holds the core's mode and divisor configuration. It sits between the SoC peripheral bus and the UART core.

## Interface
- DEPTH, 8: entries per FIFO; power of two, 2..64. Pointers are log2(DEPTH) bits; counts are log2(DEPTH)+1 bits.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low. One clock; all logic is on the rising edge of clk.
- wr_en  in  1  bus write strobe (one cycle).
- rd_en  in  1  bus read strobe (one cycle).
- addr  in  2  register select: 0 DATA, 1 STATUS, 2 MODE, 3 DIV.
- wdata  in  16  write data.
- rdata  out  16  read data, registered.
- irq  out  1  level interrupt to the interrupt controller.
- uart_mode  out  8  mode byte to the core.
- uart_div  out  16  baud divisor to the core.
- uart_send  out  1  transmit request to the core.
- uart_txreg  out  8  byte being transmitted.
- uart_txbusy  in  1  core transmitter busy; asynchronous to clk.
- uart_rxreg  in  8  core received byte.
- uart_rxerr  in  1  core receive parity/frame error; asynchronous to clk.
- uart_rxint  in  1  core receive-complete interrupt (INT_R); asynchronous to clk.

## Operation
- Synchronizers: uart_txbusy, uart_rxint and uart_rxerr each pass through a 2-FF synchronizer, giving txbusy_s, rxint_s and rxerr_s.
- rxint edge detect: a third register holds the previous rxint_s; a rising edge of rxint_s generates rx_evt.
- DATA write: pushes wdata[7:0] into the TX FIFO if the FIFO is not full at that cycle, evaluated before any same-cycle pop. If full, the byte is dropped and sticky tx_ovf is set.
- DATA read: returns {8'h00, RX head} and pops the RX FIFO. If the RX FIFO is empty, returns 16'h0000 and does not pop.
- STATUS read fields:
  - [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full.
  - [4] tx_active (FSM not in IDLE).
  - [5] tx_ovf, [6] rx_ovf, [7] rx_err (sticky bits).
  - [14:8] rx_count, zero-extended. [15] is 0.
- STATUS write: write-1-to-clear on bits [7:5]; all other bits are ignored.
- MODE register:
  - [7:0] drives uart_mode.
  - [8] rx_ie, [9] tx_ie.
  - Read returns {6'b0, bits[9:0]}.
- DIV register: [15:0] drives uart_div. Reads return the register value.
- RX capture on rx_evt:
  - Push uart_rxreg into the RX FIFO; if the FIFO is full, drop the byte and set rx_ovf.
  - If rxerr_s = 1, set rx_err.
  - A push and a bus pop in the same cycle are both performed; the count is unchanged.
- irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty & FSM==IDLE).
- TX FSM:
  - IDLE: if the TX FIFO is not empty, pop the head into uart_txreg and go to REQ.
  - REQ: uart_send = 1. When txbusy_s = 1, go to BUSY.
  - BUSY: uart_send = 0. When txbusy_s = 0, go to IDLE.
  - There is no timeout. With the core disabled (mode bits clear), the FSM waits in REQ indefinitely.

## Timing
- Reset values:
  - rdata 0, irq 0, uart_send 0, uart_txreg 0.
  - uart_mode 8'h00, uart_div 16'h0048.
  - Both FIFOs empty; sticky bits 0; FSM in IDLE.
- Reset mid-transfer: the FSM returns to IDLE and uart_send drops on the same edge. FIFO contents are discarded.
- rdata latency: valid on the cycle after rd_en. rdata holds its value until the next read.
- Register writes take effect on the next edge; the new value is on uart_mode/uart_div one cycle after wr_en.
- Simultaneous wr_en and rd_en are both serviced.
- Pop-to-send latency: the FIFO pop occurs on the IDLE-exit edge, and uart_send rises on that same edge, with uart_txreg already stable.
- uart_txreg is stable from REQ until the next pop.
- Back-to-back bytes cost at least 2 clk per byte beyond the core's busy time, plus synchronizer delay.
- RX capture: a byte is in the FIFO 3 clk after uart_rxint rises (2 synchronizer stages + edge register). uart_rxreg must be stable for that long, which is guaranteed by the core's baud rate.
- FIFO pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.

## Test plan
- Reset: rst=0 for 2 clk -> STATUS reads 16'h0005, MODE reads 0, DIV reads 16'h0048, uart_send=0, irq=0.
- Single TX: write DATA=16'h00A5 -> uart_txreg=8'hA5 with uart_send=1 in the next cycle. Model busy high for 50 clk -> send drops within 3 clk of busy rising; FSM back in IDLE 3 clk after busy falls.
- TX overflow, DEPTH=8, core disabled: write 10 bytes -> tx_full=1, tx_ovf=1, 9 bytes held (1 in REQ, 8 in FIFO). Write STATUS=16'h0020 -> tx_ovf=0.
- RX burst: 9 rxint pulses carrying 8'h01..8'h09 with rx_ie=1 -> irq=1, rx_count=8, rx_ovf=1. Reads return 01..08, then 0000; irq=0 after the 8th read.
- RX error: rxint pulse with uart_rxerr=1 and byte 8'h3C -> byte stored, STATUS[7]=1. Simultaneous DATA read and rx_evt: count unchanged.
- Reset during REQ: rst=0 while uart_send=1 -> uart_send=0 on the next edge, TX FIFO empty, tx_active=0.
